// File: rtl/bcm_pkg.sv
// Shared definitions for the bcm code mapper and its downstream code packer.
package bcm_pkg;

  localparam logic [1:0] CODE_00  = 2'b00;
  localparam logic [1:0] CODE_01  = 2'b01;
  localparam logic [1:0] CODE_10  = 2'b10;
  localparam logic [1:0] CODE_11  = 2'b11;
  localparam logic [1:0] HIT_CODE = CODE_11;

  localparam int unsigned HIT_CNT_W = 8;

  typedef enum logic [1:0] {
    ASM_IDLE = 2'd0,
    ASM_FILL = 2'd1,
    ASM_FULL = 2'd2
  } asm_state_e;

  // Assembly state is implied by the fill count rather than stored separately.
  function automatic asm_state_e asm_state(input logic [3:0] cnt, input logic [3:0] n);
    asm_state_e s;
    if (cnt == 4'd0)  s = ASM_IDLE;
    else if (cnt == n) s = ASM_FULL;
    else               s = ASM_FILL;
    return s;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/bcm_code_packer.sv
// Packs 2-bit bcm codes LSB-first into N_CODES-slot words behind a registered
// valid/ready output, and counts accepted hit codes.
module bcm_code_packer
  import bcm_pkg::*;
#(
  parameter int unsigned N_CODES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [1:0]             in_code,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [2*N_CODES-1:0]   out_word,
  output logic [3:0]             out_count,
  input  logic                   out_ready,
  output logic [HIT_CNT_W-1:0]   hit_cnt
);

  localparam int unsigned W     = 2 * N_CODES;
  localparam logic [3:0]  N_CNT = 4'(N_CODES);

  logic [W-1:0] asm_word, asm_word_nxt;
  logic [3:0]   asm_cnt, asm_cnt_nxt;
  logic         flush_pend, flush_pend_nxt;
  logic [3:0]   wr_idx;
  logic         accept, slot_free, xfer;
  asm_state_e   state;

  always_comb begin
    state     = asm_state(asm_cnt, N_CNT);
    in_ready  = (state != ASM_FULL);
    accept    = in_valid && in_ready;
    slot_free = !out_valid || out_ready;
    xfer      = slot_free &&
                ((state == ASM_FULL) || ((flush || flush_pend) && (state != ASM_IDLE)));

    // Clearing the assembler on transfer keeps unfilled slots zero, and lets a
    // same-cycle accept land in slot 0 of the next word.
    wr_idx         = xfer ? 4'd0 : asm_cnt;
    asm_word_nxt   = xfer ? '0 : asm_word;
    asm_cnt_nxt    = xfer ? 4'd0 : asm_cnt;
    flush_pend_nxt = xfer ? 1'b0
                          : (flush_pend || (flush && ((state != ASM_IDLE) || accept)));

    if (accept) begin
      for (int unsigned k = 0; k < N_CODES; k++) begin
        if (wr_idx == 4'(k)) asm_word_nxt[2*k +: 2] = in_code;
      end
      asm_cnt_nxt = asm_cnt_nxt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_word   <= '0;
      asm_cnt    <= '0;
      flush_pend <= 1'b0;
      out_valid  <= 1'b0;
      out_word   <= '0;
      out_count  <= '0;
    end else begin
      asm_word   <= asm_word_nxt;
      asm_cnt    <= asm_cnt_nxt;
      flush_pend <= flush_pend_nxt;
      if (xfer) begin
        out_valid <= 1'b1;
        out_word  <= asm_word;
        out_count <= asm_cnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  sat_counter #(
    .WIDTH (HIT_CNT_W)
  ) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept && (in_code == HIT_CODE)),
    .count (hit_cnt)
  );

endmodule

// File: tb/tb_bcm_code_packer.sv
// Self-checking bench for bcm_code_packer: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_bcm_code_packer;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [1:0]   in_code = 2'b00;
  logic         in_ready;
  logic         flush = 1'b0;
  logic         out_valid;
  logic [2*N-1:0] out_word;
  logic [3:0]   out_count;
  logic         out_ready = 1'b0;
  logic [7:0]   hit_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  // reference model state
  logic [1:0]     m_asm[$];
  bit             m_pend = 1'b0;
  bit             m_ov = 1'b0;
  logic [2*N-1:0] m_word = '0;
  int             m_cnt = 0;
  int             m_hit = 0;

  always #5 clk = ~clk;

  bcm_code_packer #(
    .N_CODES (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_word  (out_word),
    .out_count (out_count),
    .out_ready (out_ready),
    .hit_cnt   (hit_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // One clock edge of the behavioural model, evaluated from pre-edge inputs.
  function automatic void model_step();
    bit acc, go, free;
    logic [2*N-1:0] w;
    if (rst) begin
      m_asm.delete();
      m_pend = 0; m_ov = 0; m_word = '0; m_cnt = 0; m_hit = 0;
      return;
    end
    acc  = in_valid && (m_asm.size() != N);
    free = !m_ov || out_ready;
    go   = free && ((m_asm.size() == N) || ((flush || m_pend) && m_asm.size() > 0));
    if (acc && in_code == 2'b11 && m_hit < 255) m_hit++;
    if (go) begin
      w = '0;
      foreach (m_asm[k]) w = w | ((2*N)'(m_asm[k]) << (2*k));
      m_word = w;
      m_cnt  = m_asm.size();
      m_ov   = 1;
      m_pend = 0;
      m_asm.delete();
    end else begin
      if (out_ready) m_ov = 0;
      if (flush && (m_asm.size() > 0 || acc)) m_pend = 1;
    end
    if (acc) m_asm.push_back(in_code);
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready",  int'(in_ready),  int'(m_asm.size() != N));
      chk("out_valid", int'(out_valid), int'(m_ov));
      chk("out_word",  int'(out_word),  int'(m_word));
      chk("out_count", int'(out_count), m_cnt);
      chk("hit_cnt",   int'(hit_cnt),   m_hit);
    end
  end

  task automatic drive(input bit v, input logic [1:0] c);
    in_valid = v;
    in_code  = c;
  endtask

  initial begin
    logic [1:0] bp [9];
    logic [1:0] pk [4];
    int lows, acc;
    bit rdy;

    bp = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b01, 2'b10};
    pk = '{2'b11, 2'b01, 2'b00, 2'b11};

    // reset
    rst = 1'b1; step(); step(); rst = 1'b0;
    cmp_en = 1'b1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_hit_cnt",   int'(hit_cnt), 0);
    chk("rst_in_ready",  int'(in_ready), 1);
    chk("rst_out_count", int'(out_count), 0);

    // basic pack
    out_ready = 1'b1;
    lows = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, pk[i]); step();
      if (!in_ready) lows++;
    end
    drive(1'b0, 2'b00); step();
    chk("pack_valid", int'(out_valid), 1);
    chk("pack_word",  int'(out_word), 8'hC7);
    chk("pack_count", int'(out_count), 4);
    chk("pack_hit",   int'(hit_cnt), 2);
    if (!in_ready) lows++;
    step();
    if (!in_ready) lows++;
    chk("pack_in_ready_low_cycles", lows, 1);

    // flush
    drive(1'b1, 2'b01); step();
    drive(1'b1, 2'b11); step();
    drive(1'b0, 2'b00); flush = 1'b1; step(); flush = 1'b0;
    chk("flush_valid", int'(out_valid), 1);
    chk("flush_word",  int'(out_word), 8'h0D);
    chk("flush_count", int'(out_count), 2);
    step();
    flush = 1'b1; step(); flush = 1'b0; step();
    chk("flush_empty_no_out", int'(out_valid), 0);

    // backpressure
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, bp[(acc > 8) ? 8 : acc]);
      rdy = in_ready;
      step();
      if (rdy) acc++;
    end
    chk("bp_accepted", acc, 8);
    chk("bp_in_ready", int'(in_ready), 0);
    chk("bp_hold_word", int'(out_word), 8'h39);
    chk("bp_hold_count", int'(out_count), 4);
    out_ready = 1'b1;
    drive(1'b1, bp[8]); rdy = in_ready; step(); if (rdy) acc++;
    chk("bp_second_valid", int'(out_valid), 1);
    chk("bp_second_word",  int'(out_word), 8'h4F);
    rdy = in_ready; step(); if (rdy) acc++;
    chk("bp_ninth_accepted", acc, 9);
    drive(1'b0, 2'b00); flush = 1'b1; step(); flush = 1'b0;
    chk("bp_ninth_word",  int'(out_word), 8'h02);
    chk("bp_ninth_count", int'(out_count), 1);
    step();

    // pending flush
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin drive(1'b1, 2'b01); step(); end
    drive(1'b0, 2'b00); step();
    drive(1'b1, 2'b10); step();
    drive(1'b1, 2'b11); step();
    drive(1'b1, 2'b01); step();
    drive(1'b0, 2'b00); flush = 1'b1; step(); flush = 1'b0;
    step();
    chk("pend_hold_word",  int'(out_word), 8'h55);
    chk("pend_hold_count", int'(out_count), 4);
    out_ready = 1'b1;
    drive(1'b1, 2'b11); step();
    chk("pend_fire_valid", int'(out_valid), 1);
    chk("pend_fire_count", int'(out_count), 3);
    chk("pend_fire_word",  int'(out_word), 8'h1E);
    drive(1'b0, 2'b00); flush = 1'b1; step(); flush = 1'b0;
    chk("pend_next_count", int'(out_count), 1);
    chk("pend_next_word",  int'(out_word), 8'h03);
    step();

    // saturation
    acc = 0;
    for (int i = 0; i < 400 && acc < 300; i++) begin
      drive(1'b1, 2'b11); rdy = in_ready; step(); if (rdy) acc++;
    end
    chk("sat_accepted", acc, 300);
    chk("sat_hit", int'(hit_cnt), 255);
    for (int i = 0; i < 5; i++) step();
    chk("sat_hold", int'(hit_cnt), 255);

    // reset mid-operation
    drive(1'b0, 2'b00); flush = 1'b1; step(); flush = 1'b0; step(); step();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 2'b11); step(); end
    rst = 1'b1; step(); rst = 1'b0;
    drive(1'b0, 2'b00);
    chk("rstmid_out_valid", int'(out_valid), 0);
    chk("rstmid_hit", int'(hit_cnt), 0);
    chk("rstmid_in_ready", int'(in_ready), 1);
    step();
    chk("rstmid_no_word", int'(out_valid), 0);
    drive(1'b1, 2'b00); step();
    drive(1'b1, 2'b00); step();
    drive(1'b1, 2'b00); step();
    drive(1'b1, 2'b01); step();
    drive(1'b0, 2'b00); step();
    chk("rstmid_word",  int'(out_word), 8'h40);
    chk("rstmid_count", int'(out_count), 4);

    // randomized traffic, checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_code   = 2'($urandom_range(0, 3));
      flush     = ($urandom_range(0, 11) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcm_code_packer.md
# bcm_code_packer

Downstream consumer of the `bcm` 3-to-2 code mapper. It accepts the 2-bit codes that `bcm` produces, one per valid/ready transfer, and packs N_CODES of them LSB-first into one word. Each word is presented on a registered valid/ready output port. The block also keeps a saturating count of `2'b11` codes, which `bcm` emits for inputs 0, 2, 4 and 5.

## Interface
- N_CODES, default 4: codes per word; output word width is 2*N_CODES; legal range 2..8.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  `in_code` is valid this cycle.
- in_code  in  2  code from `bcm.o`.
- in_ready  out  1  block can accept a code this cycle.
- flush  in  1  single-cycle pulse; emit a partially filled word.
- out_valid  out  1  `out_word` / `out_count` are valid.
- out_word  out  2*N_CODES  packed codes; slot k occupies bits [2k+1:2k].
- out_count  out  4  number of valid slots in `out_word`, 1..N_CODES.
- out_ready  in  1  downstream accepts the word this cycle.
- hit_cnt  out  8  accepted codes equal to `2'b11` since reset; saturates at 255.

## Operation
- Internal state:
  - Assembly register `asm_word` with fill count `asm_cnt` (0..N_CODES).
  - Output register driving `out_*`.
  - `flush_pend` flag.
- Assembly FSM, encoded by `asm_cnt`:
  - IDLE: `asm_cnt` = 0.
  - FILL: 0 < `asm_cnt` < N_CODES.
  - FULL: `asm_cnt` = N_CODES.
- Accept: `in_valid` && `in_ready`. The code is written to slot `asm_cnt`, then `asm_cnt` increments.
  - IDLE→FILL, or FILL→FULL when the last slot fills.
- `in_ready` = (`asm_cnt` != N_CODES). It depends only on registers; there is no combinational path from `out_ready`.
- Output slot free: !`out_valid` || `out_ready`.
- Transfer condition: (FULL, or (`flush` || `flush_pend`) with `asm_cnt` > 0), and output slot free.
- On transfer:
  - `out_word` ← `asm_word`, with unfilled slots forced to 0.
  - `out_count` ← `asm_cnt`; `out_valid` ← 1.
  - `asm_cnt` ← 0 and `flush_pend` ← 0.
- Accept in the same cycle as a flush transfer: the code goes to slot 0 of the next word, so `asm_cnt` becomes 1.
- Flush with `asm_cnt` = 0 (and no accept that cycle) is ignored.
- Flush that cannot transfer because the output slot is busy sets `flush_pend`. The pending flush fires on the first cycle the slot frees.
- Flush arriving in the same cycle as the first accept into an empty assembler: the flush is latched and the 1-code word emits on the next cycle.
- Output handshake: `out_valid` && `out_ready` consumes the word.
  - `out_valid` drops unless a transfer refills it in the same cycle.
  - While `out_valid` && !`out_ready`, `out_word` and `out_count` hold stable.
- `hit_cnt` increments on every accepted `in_code` = `2'b11` and sticks at 255.
- `rst` takes priority over all inputs; inputs are ignored while `rst` is high.

## Timing
- Reset values:
  - `out_valid` = 0, `out_word` = 0, `out_count` = 0, `hit_cnt` = 0.
  - `asm_cnt` = 0, `flush_pend` = 0.
  - `in_ready` = 1 from the first cycle after reset.
- Latency: the Nth code is accepted at edge t and the transfer happens at edge t+1, so `out_valid` is high in the cycle after t+1 if the output slot was free.
- Flush latency: a flush pulse at edge t gives `out_valid` after edge t if the slot is free.
- Throughput: N_CODES codes per N_CODES+1 cycles with no backpressure, because `in_ready` is low for one cycle in FULL.
- Full backpressure: at most 2*N_CODES codes are buffered (one word in the output register, one in assembly). `in_ready` stays low until the output word is consumed.
- Reset mid-word: the partial word and the pending output are discarded; no word is emitted.

## Structure
- Shared package `bcm_pkg`:
  - Code constants `CODE_00`..`CODE_11`, with `HIT_CODE` = `2'b11`.
  - Assembly state encoding (IDLE/FILL/FULL).
  - `HIT_CNT_W` = 8.
- Sub-module `sat_counter` (width parameter, `inc` input, saturating) implements `hit_cnt`.
- Everything else lives in `bcm_code_packer`.

## Test plan
- Basic pack (N_CODES=4): codes 11, 01, 00, 11 on consecutive cycles, `out_ready`=1 → one word `out_word`=8'hC7, `out_count`=4, `hit_cnt`=2; `in_ready` low exactly one cycle.
- Flush: codes 01, 11 then a `flush` pulse → `out_word`=8'h0D, `out_count`=2. A second `flush` with the assembler empty → no output.
- Backpressure: `out_ready`=0, offer 9 codes → 8 accepted; `in_ready` stays 0 and the first word holds stable. Raise `out_ready` → the first word is consumed, the second word appears the next cycle, and the 9th code is then accepted.
- Pending flush: output busy, 3 codes assembled, `flush` pulse → emits after the output drains, with `out_count`=3. A code offered in the flush-transfer cycle starts the next word with `asm_cnt`=1.
- Saturation: 300 accepted `2'b11` codes → `hit_cnt`=255 and holds.
- Reset mid-operation: 3 codes accepted, `rst` for one cycle → `out_valid`=0, `hit_cnt`=0, no word emitted. The next 4 codes (00, 00, 00, 01) give `out_word`=8'h40.
